// File: rtl/ace_3state_fsm.sv
// ---------------------------------------------------------------------------
// ace_3state_fsm
//   Coherence controller for a single cache line. It implements a reduced ACE
//   model with three states: INVALID, UNIQUE_CLEAN and UNIQUE_DIRTY. Local
//   read/write requests and incoming snoops are decoded once per clock. The
//   block drives a registered one-hot state indication and registered
//   one-cycle action strobes towards the cache data array and memory port.
//
//   Build option: define ACE_WRITE_ALLOCATE_EN to allocate the line on a
//   write miss. In that build, awvalid in INVALID moves to UNIQUE_DIRTY and
//   pulses write_cache. In the default build the write goes straight to
//   memory and the line stays INVALID.
//
//   Handshake: a snoop is taken only when acvalid & crready are both high
//   on a rising edge. acvalid with crready low is a stalled snoop; it does
//   nothing and does not block lower-priority requests. awvalid and arvalid
//   are level requests with no back-pressure. Each high cycle is one
//   request, and a request held high repeats its action every cycle.
//   Priority per edge: snoop > write > read.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   acvalid        in   snoop request valid
//   awvalid        in   local write request
//   arvalid        in   local read request
//   crready        in   snoop response channel ready
//   acsnoop        in   snoop type: 0 = clean (keep copy), 1 = invalidating
//   invalid        out  state == INVALID
//   unique_clean   out  state == UNIQUE_CLEAN
//   unique_dirty   out  state == UNIQUE_DIRTY
//   write_main_mem out  strobe: write line/data to main memory
//   write_cache    out  strobe: write data into cache line
//   read_main_mem  out  strobe: fetch line from main memory
//   read_cache     out  strobe: read data from cache line
// ---------------------------------------------------------------------------
module ace_3state_fsm (
  input  logic clk,
  input  logic rst_n,
  input  logic acvalid,
  input  logic awvalid,
  input  logic arvalid,
  input  logic crready,
  input  logic acsnoop,
  output logic invalid,
  output logic unique_clean,
  output logic unique_dirty,
  output logic write_main_mem,
  output logic write_cache,
  output logic read_main_mem,
  output logic read_cache
);

  localparam logic [1:0] ST_INVALID      = 2'b00;
  localparam logic [1:0] ST_UNIQUE_CLEAN = 2'b01;
  localparam logic [1:0] ST_UNIQUE_DIRTY = 2'b10;

  logic [1:0] state_q, state_d;
  logic       invalid_q, invalid_d;
  logic       unique_clean_q, unique_clean_d;
  logic       unique_dirty_q, unique_dirty_d;
  logic       write_main_mem_q, write_main_mem_d;
  logic       write_cache_q, write_cache_d;
  logic       read_main_mem_q, read_main_mem_d;
  logic       read_cache_q, read_cache_d;
  logic       snp;

  assign snp = acvalid & crready;

  always_comb begin
    state_d          = state_q;
    write_main_mem_d = 1'b0;
    write_cache_d    = 1'b0;
    read_main_mem_d  = 1'b0;
    read_cache_d     = 1'b0;

    case (state_q)
      ST_INVALID: begin
        if (snp) begin
          // Nothing is cached, so there is nothing to supply or drop.
          state_d = ST_INVALID;
        end else if (awvalid) begin
`ifdef ACE_WRITE_ALLOCATE_EN
          state_d       = ST_UNIQUE_DIRTY;
          write_cache_d = 1'b1;
`else
          write_main_mem_d = 1'b1;
`endif
        end else if (arvalid) begin
          state_d         = ST_UNIQUE_CLEAN;
          read_main_mem_d = 1'b1;
        end
      end

      ST_UNIQUE_CLEAN: begin
        if (snp) begin
          // The clean copy matches memory, so no writeback is needed.
          if (acsnoop) state_d = ST_INVALID;
        end else if (awvalid) begin
          state_d       = ST_UNIQUE_DIRTY;
          write_cache_d = 1'b1;
        end else if (arvalid) begin
          read_cache_d = 1'b1;
        end
      end

      ST_UNIQUE_DIRTY: begin
        if (snp) begin
          // Dirty data must reach memory before the copy is shared or dropped.
          write_main_mem_d = 1'b1;
          state_d          = acsnoop ? ST_INVALID : ST_UNIQUE_CLEAN;
        end else if (awvalid) begin
          write_cache_d = 1'b1;
        end else if (arvalid) begin
          read_cache_d = 1'b1;
        end
      end

      default: begin
        // Illegal encoding 2'b11: return to a safe state with no side effects.
        state_d = ST_INVALID;
      end
    endcase

    // The one-hot flags are registered copies of the next state. They stay
    // one-hot even if the binary state register holds the illegal code.
    invalid_d      = (state_d == ST_INVALID);
    unique_clean_d = (state_d == ST_UNIQUE_CLEAN);
    unique_dirty_d = (state_d == ST_UNIQUE_DIRTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_INVALID;
      invalid_q        <= 1'b1;
      unique_clean_q   <= 1'b0;
      unique_dirty_q   <= 1'b0;
      write_main_mem_q <= 1'b0;
      write_cache_q    <= 1'b0;
      read_main_mem_q  <= 1'b0;
      read_cache_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      invalid_q        <= invalid_d;
      unique_clean_q   <= unique_clean_d;
      unique_dirty_q   <= unique_dirty_d;
      write_main_mem_q <= write_main_mem_d;
      write_cache_q    <= write_cache_d;
      read_main_mem_q  <= read_main_mem_d;
      read_cache_q     <= read_cache_d;
    end
  end

  assign invalid        = invalid_q;
  assign unique_clean   = unique_clean_q;
  assign unique_dirty   = unique_dirty_q;
  assign write_main_mem = write_main_mem_q;
  assign write_cache    = write_cache_q;
  assign read_main_mem  = read_main_mem_q;
  assign read_cache     = read_cache_q;

endmodule

// File: tb/tb_ace_3state_fsm.sv
// ---------------------------------------------------------------------------
// tb_ace_3state_fsm
//   Directed, table-driven bench for ace_3state_fsm. Each table row holds
//   the inputs for one clock and the hand-computed outputs expected after
//   that edge. Hand-written sequences cover the asynchronous reset corners.
//   The rows that depend on ACE_WRITE_ALLOCATE_EN carry both expectations.
// ---------------------------------------------------------------------------
module tb_ace_3state_fsm;

  // Output vector order: {invalid, unique_clean, unique_dirty,
  //                       write_main_mem, write_cache, read_main_mem, read_cache}
  localparam logic [6:0] S_INV = 7'b100_0000;
  localparam logic [6:0] S_UC  = 7'b010_0000;
  localparam logic [6:0] S_UD  = 7'b001_0000;
  localparam logic [6:0] A_WMM = 7'b000_1000;
  localparam logic [6:0] A_WC  = 7'b000_0100;
  localparam logic [6:0] A_RMM = 7'b000_0010;
  localparam logic [6:0] A_RC  = 7'b000_0001;

  // Input vector order: {acvalid, crready, acsnoop, awvalid, arvalid}
  localparam logic [4:0] I_IDLE = 5'b000_00;
  localparam logic [4:0] I_AW   = 5'b000_10;
  localparam logic [4:0] I_AR   = 5'b000_01;
  localparam logic [4:0] I_SNC  = 5'b110_00;  // clean snoop accepted
  localparam logic [4:0] I_SNI  = 5'b111_00;  // invalidating snoop accepted
  localparam logic [4:0] I_STAL = 5'b101_00;  // stalled invalidating snoop

  typedef struct {
    string      name;
    logic [4:0] in;
    logic [6:0] exp;
  } vec_t;

  logic clk, rst_n;
  logic acvalid, awvalid, arvalid, crready, acsnoop;
  logic invalid, unique_clean, unique_dirty;
  logic write_main_mem, write_cache, read_main_mem, read_cache;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  ace_3state_fsm dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .acvalid        (acvalid),
    .awvalid        (awvalid),
    .arvalid        (arvalid),
    .crready        (crready),
    .acsnoop        (acsnoop),
    .invalid        (invalid),
    .unique_clean   (unique_clean),
    .unique_dirty   (unique_dirty),
    .write_main_mem (write_main_mem),
    .write_cache    (write_cache),
    .read_main_mem  (read_main_mem),
    .read_cache     (read_cache)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks.
  task automatic drive(input logic [4:0] in);
    {acvalid, crready, acsnoop, awvalid, arvalid} = in;
  endtask

  function automatic logic [6:0] outs();
    return {invalid, unique_clean, unique_dirty,
            write_main_mem, write_cache, read_main_mem, read_cache};
  endfunction

  // Scoreboard check.
  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (inv,uc,ud,wmm,wc,rmm,rc)",
               name, act, exp);
    end
  endtask

  // Apply inputs, let one rising edge pass, then sample 1 ns later.
  task automatic step(input logic [4:0] in);
    drive(in);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input logic [4:0] in,
                              input logic [6:0] exp);
    vec_t v;
    v.name = name;
    v.in   = in;
    v.exp  = exp;
    return v;
  endfunction

  initial begin
    // Stimulus table with hand-computed expected results.
    vecs.push_back(mk("idle0",            I_IDLE, S_INV));
    vecs.push_back(mk("idle1",            I_IDLE, S_INV));
`ifdef ACE_WRITE_ALLOCATE_EN
    vecs.push_back(mk("inv_aw_alloc",     I_AW,   S_UD | A_WC));
    vecs.push_back(mk("ud_snp_inv",       I_SNI,  S_INV | A_WMM));
`else
    vecs.push_back(mk("inv_aw_noalloc",   I_AW,   S_INV | A_WMM));
    vecs.push_back(mk("inv_snp_inv",      I_SNI,  S_INV));
`endif
    vecs.push_back(mk("inv_idle",         I_IDLE, S_INV));
    vecs.push_back(mk("inv_ar_fill",      I_AR,   S_UC | A_RMM));
    vecs.push_back(mk("uc_ar_hit",        I_AR,   S_UC | A_RC));
    vecs.push_back(mk("uc_idle",          I_IDLE, S_UC));
    vecs.push_back(mk("uc_snp_stall",     I_STAL, S_UC));
    vecs.push_back(mk("uc_snp_inv",       I_SNI,  S_INV));
    vecs.push_back(mk("inv_ar_fill2",     I_AR,   S_UC | A_RMM));
    vecs.push_back(mk("uc_snp_clean",     I_SNC,  S_UC));
    vecs.push_back(mk("uc_aw",            I_AW,   S_UD | A_WC));
    vecs.push_back(mk("ud_aw_held",       I_AW,   S_UD | A_WC));
    vecs.push_back(mk("ud_ar",            I_AR,   S_UD | A_RC));
    vecs.push_back(mk("ud_snp_stall",     I_STAL, S_UD));
    vecs.push_back(mk("ud_snp_clean_wb",  I_SNC,  S_UC | A_WMM));
    vecs.push_back(mk("uc_aw2",           I_AW,   S_UD | A_WC));
    vecs.push_back(mk("ud_snp_inv_wb",    I_SNI,  S_INV | A_WMM));
    vecs.push_back(mk("inv_snp_inv2",     I_SNI,  S_INV));
    vecs.push_back(mk("inv_stall_ar",     I_STAL | I_AR, S_UC | A_RMM));
    vecs.push_back(mk("uc_aw_beats_ar",   I_AW | I_AR,   S_UD | A_WC));
    vecs.push_back(mk("ud_all_snp_wins",  5'b110_11,     S_UC | A_WMM));
    vecs.push_back(mk("uc_all_snp_inv",   5'b111_11,     S_INV));

    // Reset: assert for 20 ns, release away from the rising edge.
    drive(I_IDLE);
    rst_n = 1'b0;
    #20;
    check("reset_state", S_INV);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].in);
      check(vecs[i].name, vecs[i].exp);
    end

    // Snoop priority in UNIQUE_DIRTY, then reset while a writeback strobe is
    // high. The asynchronous reset must clear it without waiting for an edge.
    step(I_AR);
    check("seq_fill", S_UC | A_RMM);
    step(I_AW);
    check("seq_dirty", S_UD | A_WC);
    step(5'b111_11);
    check("seq_snp_wins_wb", S_INV | A_WMM);
    step(I_AR);
    check("seq_refill", S_UC | A_RMM);
    step(I_AW);
    check("seq_dirty2", S_UD | A_WC);
    step(5'b110_11);
    check("seq_wb_pending", S_UC | A_WMM);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid", S_INV);
    // Requests held across an edge while reset is asserted are ignored.
    drive(I_AW | I_AR);
    @(posedge clk);
    #1;
    check("reset_held_edge", S_INV);
    drive(I_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    step(I_IDLE);
    check("post_reset_idle", S_INV);
    step(I_AR);
    check("post_reset_fill", S_UC | A_RMM);
    step(I_IDLE);
    check("post_reset_hold", S_UC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends with a summary.
  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: got no completion expected finish before 100us");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
